ic_closest_hit: RTL and testbench

//  Receiving end of the intersection-calculation pipeline: consumes per-triangle results (sid, t, hit, point, norm)

---
 rtl/ic_closest_hit_if.sv | 31 +++
 rtl/ic_closest_hit.sv | 159 +++++++++++++++
 tb/tb_ic_closest_hit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ic_closest_hit_if.sv
// Stream bundle between the intersection pipeline, the closest-hit reducer and the shader side.
// master = producer/consumer environment, slave = ic_closest_hit.
interface ic_closest_hit_if;
  logic        in_valid;
  logic [31:0] in_sid;
  logic [31:0] in_t;
  logic        in_hit;
  logic [95:0] in_point;
  logic [95:0] in_norm;
  logic        in_last;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sid;
  logic [31:0] out_t;
  logic        out_hit;
  logic [95:0] out_point;
  logic [95:0] out_norm;

  modport master (
    output in_valid, in_sid, in_t, in_hit, in_point, in_norm, in_last,
    output out_ready,
    input  out_valid, out_sid, out_t, out_hit, out_point, out_norm
  );

  modport slave (
    input  in_valid, in_sid, in_t, in_hit, in_point, in_norm, in_last,
    input  out_ready,
    output out_valid, out_sid, out_t, out_hit, out_point, out_norm
  );
endinterface

// File: rtl/ic_closest_hit.sv
// Reduces the per-triangle results of each ray to the nearest valid hit and queues one result per ray.
// Optional build macro IC_CLOSEST_HIT_STATS_EN adds ray_count / hit_count statistics outputs.
module ic_closest_hit #(
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ic_closest_hit_if.slave   bus,
  output logic              overflow,
`ifdef IC_CLOSEST_HIT_STATS_EN
  output logic              busy,
  output logic [31:0]       ray_count,
  output logic [31:0]       hit_count
`else
  output logic              busy
`endif
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] sid;
    logic [31:0] t;
    logic        hit;
    logic [95:0] point;
    logic [95:0] norm;
  } result_t;

  localparam result_t MISS = {32'hFFFF_FFFF, 32'h7F80_0000, 1'b0, 96'd0, 96'd0};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t  r_state;
  logic    r_busy;
  result_t r_best;

  result_t r_mem [OUT_DEPTH];
  result_t r_head;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic          r_overflow;

  logic    w_qual;
  logic    w_closer;
  result_t w_base;
  result_t w_sample;
  result_t w_fold;
  logic    w_push;
  logic    w_pop;
  logic    w_full;
  logic    w_push_ok;
  logic [CW-1:0] w_count_next;

  // Only strictly positive finite t (denormals included) is a candidate.
  assign w_qual = bus.in_hit && !bus.in_t[31] && (bus.in_t[30:0] != 31'd0) &&
                  (bus.in_t[30:23] != 8'hFF);

  assign w_base   = (r_state == S_ACCUM) ? r_best : MISS;
  assign w_sample = {bus.in_sid, bus.in_t, 1'b1, bus.in_point, bus.in_norm};

  // Positive IEEE floats order like their magnitude bits; strict compare keeps the earlier triangle on ties.
  assign w_closer = w_qual && (!w_base.hit || (bus.in_t[30:0] < w_base.t[30:0]));
  assign w_fold   = w_closer ? w_sample : w_base;

  assign w_push       = bus.in_valid && bus.in_last;
  assign w_pop        = r_out_valid && bus.out_ready;
  assign w_full       = (r_count == CW'(OUT_DEPTH));
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_best  <= '0;
    end else if (bus.in_valid) begin
      if (bus.in_last) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_best  <= '0;
      end else begin
        r_state <= S_ACCUM;
        r_busy  <= 1'b1;
        r_best  <= w_fold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_fold;
    end
  end

  // The head register mirrors mem[rd_ptr]; it is refilled from the push data or the next stored entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      if (w_push_ok && ((r_count == '0) || (w_pop && (r_count == CW'(1))))) begin
        r_head <= w_fold;
      end else if (w_pop && (r_count > CW'(1))) begin
        r_head <= r_mem[r_rd_ptr + AW'(1)];
      end
    end
  end

`ifdef IC_CLOSEST_HIT_STATS_EN
  logic [31:0] r_ray_count;
  logic [31:0] r_hit_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ray_count <= '0;
      r_hit_count <= '0;
    end else if (w_push) begin
      r_ray_count <= r_ray_count + 32'd1;
      if (w_fold.hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

  assign ray_count = r_ray_count;
  assign hit_count = r_hit_count;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_sid   = r_head.sid;
  assign bus.out_t     = r_head.t;
  assign bus.out_hit   = r_head.hit;
  assign bus.out_point = r_head.point;
  assign bus.out_norm  = r_head.norm;
  assign overflow      = r_overflow;
  assign busy          = r_busy;

endmodule

// File: tb/tb_ic_closest_hit.sv
// Directed plus randomized bench for ic_closest_hit against a per-ray nearest-hit model.
module tb_ic_closest_hit;
  localparam int OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overflow;
  logic busy;
`ifdef IC_CLOSEST_HIT_STATS_EN
  logic [31:0] ray_count;
  logic [31:0] hit_count;
`endif

  ic_closest_hit_if bus ();

  ic_closest_hit #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .overflow (overflow),
`ifdef IC_CLOSEST_HIT_STATS_EN
    .busy     (busy),
    .ray_count(ray_count),
    .hit_count(hit_count)
`else
    .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sid;
    logic [31:0] t;
    logic        hit;
    logic [95:0] point;
    logic [95:0] norm;
  } res_t;

  res_t mq[$];
  res_t ray[$];
  logic exp_ovf;
  int   exp_rays;
  int   exp_hits;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic qual(input res_t c);
    return c.hit && !c.t[31] && (c.t[30:0] != 31'd0) && (c.t[30:23] != 8'hFF);
  endfunction

  // Nearest qualified triangle of the ray; first one wins a tie.
  function automatic res_t nearest(input res_t tq[$]);
    res_t best;
    best.sid = 32'hFFFF_FFFF; best.t = 32'h7F80_0000; best.hit = 1'b0;
    best.point = '0; best.norm = '0;
    foreach (tq[i]) begin
      if (qual(tq[i]) && (!best.hit || tq[i].t[30:0] < best.t[30:0])) begin
        best = tq[i];
        best.hit = 1'b1;
      end
    end
    return best;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, bus.out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk({tag, ".out_sid"},   bus.out_sid,   mq[0].sid);
      chk({tag, ".out_t"},     bus.out_t,     mq[0].t);
      chk({tag, ".out_hit"},   bus.out_hit,   mq[0].hit);
      chk({tag, ".out_point"}, bus.out_point, mq[0].point);
      chk({tag, ".out_norm"},  bus.out_norm,  mq[0].norm);
    end
    chk({tag, ".overflow"}, overflow, exp_ovf);
    chk({tag, ".busy"},     busy,     ray.size() != 0);
`ifdef IC_CLOSEST_HIT_STATS_EN
    chk({tag, ".ray_count"}, ray_count, 32'(exp_rays));
    chk({tag, ".hit_count"}, hit_count, 32'(exp_hits));
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] sid, input logic [31:0] t,
                      input logic hit, input logic last, input logic rdy);
    res_t tr;
    res_t r;
    tr.sid = sid; tr.t = t; tr.hit = hit;
    tr.point = {sid, ~sid, sid ^ 32'hA5A5_A5A5};
    tr.norm  = {sid + 32'd1, sid + 32'd2, sid + 32'd3};
    bus.in_valid = v; bus.in_sid = sid; bus.in_t = t; bus.in_hit = hit;
    bus.in_point = tr.point; bus.in_norm = tr.norm; bus.in_last = last;
    bus.out_ready = rdy;
    if ((mq.size() != 0) && rdy) void'(mq.pop_front());
    if (v) begin
      ray.push_back(tr);
      if (last) begin
        r = nearest(ray);
        ray.delete();
        exp_rays++;
        if (r.hit) exp_hits++;
        if (mq.size() < OUT_DEPTH) mq.push_back(r);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); ray.delete();
    exp_ovf = 1'b0; exp_rays = 0; exp_hits = 0;
    chk({tag, ".out_sid0"}, bus.out_sid, 32'd0);
    chk({tag, ".out_t0"},   bus.out_t,   32'd0);
    chk({tag, ".out_hit0"}, bus.out_hit, 1'b0);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_t();
    case ($urandom_range(0, 11))
      0:  return 32'h3F80_0000;
      1:  return 32'h4000_0000;
      2:  return 32'h4040_0000;
      3:  return 32'h40A0_0000;
      4:  return 32'hBF80_0000;
      5:  return 32'h0000_0000;
      6:  return 32'h8000_0000;
      7:  return 32'h7F80_0000;
      8:  return 32'h7FC0_0000;
      9:  return 32'h0000_0001;
      10: return 32'h0040_0000;
      default: return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_sid = '0; bus.in_t = '0; bus.in_hit = 1'b0;
    bus.in_point = '0; bus.in_norm = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    exp_ovf = 1'b0; exp_rays = 0; exp_hits = 0;

    do_reset("reset");

    // three-triangle ray, nearest is the middle one
    step("ray3_a", 1, 32'd10, 32'h40A0_0000, 1, 0, 1);
    step("ray3_b", 1, 32'd11, 32'h4000_0000, 1, 0, 1);
    step("ray3_c", 1, 32'd12, 32'h4040_0000, 1, 1, 1);
    step("ray3_out", 0, 0, 0, 0, 0, 1);

    // all candidates rejected: negative, zero, NaN
    step("miss_a", 1, 32'd20, 32'hBF80_0000, 1, 0, 1);
    step("miss_b", 1, 32'd21, 32'h0000_0000, 1, 0, 1);
    step("miss_c", 1, 32'd22, 32'h7FC0_0000, 1, 1, 1);
    step("miss_out", 0, 0, 0, 0, 0, 1);

    // single-triangle ray from idle, then a tie
    step("single", 1, 32'd30, 32'h3F80_0000, 1, 1, 0);
    step("single_out", 0, 0, 0, 0, 0, 1);
    step("tie_a", 1, 32'd40, 32'h4000_0000, 1, 0, 1);
    step("tie_b", 1, 32'd41, 32'h4000_0000, 1, 1, 1);
    step("tie_out", 0, 0, 0, 0, 0, 1);

    // ray with gaps and a denormal winner
    step("gap_a", 1, 32'd50, 32'h3F80_0000, 1, 0, 1);
    step("gap_idle1", 0, 0, 0, 0, 0, 1);
    step("gap_idle2", 0, 0, 0, 0, 0, 1);
    step("gap_b", 1, 32'd51, 32'h0000_0001, 1, 0, 1);
    step("gap_c", 1, 32'd52, 32'h0000_0000, 1, 1, 1);
    step("gap_out", 0, 0, 0, 0, 0, 1);

    // overfill with a stalled consumer, then drain
    for (int i = 0; i <= OUT_DEPTH; i++)
      step("fill", 1, 32'(100 + i), 32'(32'h3F80_0000 + i), 1, 1, 0);
    for (int i = 0; i < OUT_DEPTH + 2; i++)
      step("drain", 0, 0, 0, 0, 0, 1);

    // full FIFO with simultaneous pop and push loses nothing
    do_reset("reset2");
    for (int i = 0; i < OUT_DEPTH; i++)
      step("fill2", 1, 32'(200 + i), 32'h4000_0000, 1, 1, 0);
    step("push_pop_full", 1, 32'd210, 32'h4040_0000, 1, 1, 1);
    for (int i = 0; i < OUT_DEPTH + 1; i++)
      step("drain2", 0, 0, 0, 0, 0, 1);

    // reset in the middle of a ray discards it
    step("mid_a", 1, 32'd300, 32'h3F80_0000, 1, 0, 1);
    step("mid_b", 1, 32'd301, 32'h4000_0000, 1, 0, 1);
    do_reset("reset_mid");
    step("after_mid", 0, 0, 0, 0, 0, 1);

    // randomized rays, gaps and back-pressure
    for (int r = 0; r < 250; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0)
          step("rnd_gap", 0, 0, 0, 0, 0, $urandom_range(0, 2) != 0);
        step("rnd", 1, 32'(1000 + r * 8 + k), rand_t(), $urandom_range(0, 4) != 0,
             k == n - 1, $urandom_range(0, 2) != 0);
      end
    end
    for (int i = 0; i < OUT_DEPTH + 2; i++)
      step("rnd_drain", 0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
